// File: rtl/pattern_gen.sv
// pattern_gen: serial pattern transmitter, MSB-first, with a repeat count.
// Outputs decode from registered state only.
module pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         pattern,
  input  logic [$clog2(WIDTH)-1:0] len,
  input  logic [CW-1:0]            reps,
  output logic                     y,
  output logic                     yvalid,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] pat, pat_n;
  logic [LW-1:0]   llen, llen_n;
  logic [LW-1:0]   idx, idx_n;
  logic [CW-1:0]   lreps, lreps_n;
  logic [CW-1:0]   pass, pass_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pat   <= '0;
      llen  <= '0;
      idx   <= '0;
      lreps <= '0;
      pass  <= '0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      llen  <= llen_n;
      idx   <= idx_n;
      lreps <= lreps_n;
      pass  <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat;
    llen_n  = llen;
    idx_n   = idx;
    lreps_n = lreps;
    pass_n  = pass;
    unique case (state)
      IDLE: begin
        if (start) begin
          pat_n   = pattern;
          llen_n  = len;
          lreps_n = reps;
          idx_n   = len;
          pass_n  = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (idx != '0) begin
          idx_n = idx - 1'b1;
        end else if (pass != lreps) begin
          // Reload for the next pass with no gap cycle.
          idx_n  = llen;
          pass_n = pass + 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    yvalid = (state == SEND);
    y      = (state == SEND) & pat[idx];
    busy   = (state == SEND) | (state == DONE);
    done   = (state == DONE);
  end

endmodule
